// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - ALU issue sequencer: decode one R/I instruction, drive the ALU, write the result back
module alu_issue_seq #(
    parameter int XLEN    = 32,
    parameter int ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] srcA,
    output logic [XLEN-1:0] srcB,
    output logic [2:0]      ALUControl,
    input  logic [XLEN-1:0] alu_res,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Countdown starts at ALU_LAT; one extra cycle is spent at zero before sampling alu_res.
    localparam logic [2:0] CNT_INIT = 3'(ALU_LAT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_WAIT = 3'd2,
        S_WB   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] src_a_q, src_a_d;
    logic [XLEN-1:0] src_b_q, src_b_d;
    logic [2:0]      alu_ctrl_q, alu_ctrl_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            illegal_q, illegal_d;
    logic            instr_ready_q, instr_ready_d;

    logic            dec_legal;
    logic [2:0]      dec_ctrl;
    logic [XLEN-1:0] dec_src_b;
    logic [XLEN-1:0] imm_sext;

    // The rs1 register index is resolved upstream; its value arrives on rs1_data.
    logic            unused_rs1_idx;
    assign unused_rs1_idx = ^instr[19:15];

    assign imm_sext = {{(XLEN-12){instr[31]}}, instr[31:20]};

    // Instruction decode: legality, ALU operation and operand B source
    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = ALU_ADD;
        dec_src_b = rs2_data;
        case (instr[6:0])
            OP_R: begin
                if (instr[31:25] == 7'b0000000) begin
                    case (instr[14:12])
                        3'b000: begin dec_legal = 1'b1; dec_ctrl = ALU_ADD; end
                        3'b111: begin dec_legal = 1'b1; dec_ctrl = ALU_AND; end
                        3'b110: begin dec_legal = 1'b1; dec_ctrl = ALU_OR;  end
                        3'b010: begin dec_legal = 1'b1; dec_ctrl = ALU_SLT; end
                        default: dec_legal = 1'b0;
                    endcase
                end else if (instr[31:25] == 7'b0100000 && instr[14:12] == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = ALU_SUB;
                end
            end
            OP_I: begin
                dec_src_b = imm_sext;
                case (instr[14:12])
                    3'b000: begin dec_legal = 1'b1; dec_ctrl = ALU_ADD; end
                    3'b111: begin dec_legal = 1'b1; dec_ctrl = ALU_AND; end
                    3'b110: begin dec_legal = 1'b1; dec_ctrl = ALU_OR;  end
                    3'b010: begin dec_legal = 1'b1; dec_ctrl = ALU_SLT; end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Sequencer next-state and next-output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        alu_ctrl_d = alu_ctrl_q;
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        illegal_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    cnt_d = CNT_INIT;
                    if (dec_legal) begin
                        state_d    = S_EXEC;
                        src_a_d    = rs1_data;
                        src_b_d    = dec_src_b;
                        alu_ctrl_d = dec_ctrl;
                        rd_d       = instr[11:7];
                    end else begin
                        // Operands keep their old values; only the op code is parked at add.
                        state_d    = S_ERR;
                        alu_ctrl_d = ALU_ADD;
                        illegal_d  = 1'b1;
                    end
                end
            end
            S_EXEC, S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (rd_q == 5'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_WB;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = alu_res;
                    end
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    state_d = S_WAIT;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        instr_ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs; async reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 3'd0;
            rd_q          <= 5'd0;
            src_a_q       <= '0;
            src_b_q       <= '0;
            alu_ctrl_q    <= 3'd0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= '0;
            illegal_q     <= 1'b0;
            instr_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_q          <= rd_d;
            src_a_q       <= src_a_d;
            src_b_q       <= src_b_d;
            alu_ctrl_q    <= alu_ctrl_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            illegal_q     <= illegal_d;
            instr_ready_q <= instr_ready_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign srcA        = src_a_q;
    assign srcB        = src_b_q;
    assign ALUControl  = alu_ctrl_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - self-checking bench for alu_issue_seq with a transaction-level reference model
module tb_alu_issue_seq;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        instr_valid = 1'b0, instr_ready, wb_valid, wb_ready = 1'b0, illegal;
    logic [31:0] instr = '0, rs1_data = '0, rs2_data = '0, src_a, src_b, alu_res, wb_data;
    logic [2:0]  alu_ctrl;
    logic [4:0]  wb_rd;

    logic        iv3 = 1'b0, ready3, wbv3, wbr3 = 1'b1, illegal3;
    logic [31:0] ins3 = '0, a3 = '0, b3 = '0, src_a3, src_b3, alu_res3, wb_data3;
    logic [2:0]  ctrl3;
    logic [4:0]  rd3;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu_issue_seq #(.XLEN(32), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .srcA(src_a), .srcB(src_b),
        .ALUControl(alu_ctrl), .alu_res(alu_res), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal)
    );

    alu_issue_seq #(.XLEN(32), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .instr_valid(iv3), .instr_ready(ready3),
        .instr(ins3), .rs1_data(a3), .rs2_data(b3), .srcA(src_a3), .srcB(src_b3),
        .ALUControl(ctrl3), .alu_res(alu_res3), .wb_valid(wbv3), .wb_ready(wbr3),
        .wb_rd(rd3), .wb_data(wb_data3), .illegal(illegal3)
    );

    function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    // ALU behind each DUT: result appears the given number of clocks after the operands
    logic [31:0] pipe3 [3];
    always @(posedge clk) begin
        alu_res  <= alu_f(alu_ctrl, src_a, src_b);
        pipe3[0] <= alu_f(ctrl3, src_a3, src_b3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign alu_res3 = pipe3[2];

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Reference decode: table of supported (opcode, funct7, funct3) combinations
    function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] rs2v,
                                       output bit ok, output logic [2:0] c, output logic [31:0] b);
        ok = 1'b1;
        c  = 3'b000;
        b  = rs2v;
        if (ins[6:0] == 7'b0110011) begin
            case ({ins[31:25], ins[14:12]})
                {7'h00, 3'b000}: c = 3'b000;
                {7'h20, 3'b000}: c = 3'b001;
                {7'h00, 3'b111}: c = 3'b010;
                {7'h00, 3'b110}: c = 3'b011;
                {7'h00, 3'b010}: c = 3'b101;
                default:         ok = 1'b0;
            endcase
        end else if (ins[6:0] == 7'b0010011) begin
            b = {{20{ins[31]}}, ins[31:20]};
            case (ins[14:12])
                3'b000:  c = 3'b000;
                3'b111:  c = 3'b010;
                3'b110:  c = 3'b011;
                3'b010:  c = 3'b101;
                default: ok = 1'b0;
            endcase
        end else begin
            ok = 1'b0;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs after every clock edge, tracked per transaction
    logic        m_ready, m_illegal, m_wb_valid;
    logic [31:0] m_srca, m_srcb, m_wb_data, m_res;
    logic [2:0]  m_ctrl;
    logic [4:0]  m_wb_rd, m_rd;
    bit          m_busy, m_err, m_wb;
    int          m_left;

    initial begin
        bit          ok;
        logic [2:0]  c;
        logic [31:0] b;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ready = 1'b1; m_illegal = 1'b0; m_wb_valid = 1'b0;
                m_srca = '0; m_srcb = '0; m_ctrl = '0; m_wb_rd = '0; m_wb_data = '0;
                m_busy = 1'b0; m_err = 1'b0; m_wb = 1'b0; m_left = 0; m_rd = '0; m_res = '0;
            end else begin
                m_illegal = 1'b0;
                if (!m_busy) begin
                    if (instr_valid) begin
                        ref_decode(instr, rs2_data, ok, c, b);
                        m_busy = 1'b1;
                        if (!ok) begin
                            m_err = 1'b1; m_ctrl = 3'b000; m_illegal = 1'b1;
                        end else begin
                            m_srca = rs1_data; m_srcb = b; m_ctrl = c;
                            m_res  = alu_f(c, rs1_data, b);
                            m_rd   = instr[11:7];
                            m_left = LAT + 1;
                        end
                    end
                end else if (m_err) begin
                    m_err = 1'b0; m_busy = 1'b0;
                end else if (m_wb) begin
                    if (wb_ready) begin
                        m_wb = 1'b0; m_busy = 1'b0; m_wb_valid = 1'b0;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_rd == 5'd0) begin
                            m_busy = 1'b0;
                        end else begin
                            m_wb = 1'b1; m_wb_valid = 1'b1; m_wb_rd = m_rd; m_wb_data = m_res;
                        end
                    end
                end
                m_ready = !m_busy;
            end
        end
    end

    // Compare DUT against the model in the middle of every cycle
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("m_ready", 32'(instr_ready), 32'(m_ready));
            chk("m_srca", src_a, m_srca);
            chk("m_srcb", src_b, m_srcb);
            chk("m_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
            chk("m_wb_valid", 32'(wb_valid), 32'(m_wb_valid));
            chk("m_illegal", 32'(illegal), 32'(m_illegal));
            if (m_wb_valid) begin
                chk("m_wb_rd", 32'(wb_rd), 32'(m_wb_rd));
                chk("m_wb_data", wb_data, m_wb_data);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", 32'(instr_ready), 32'd1);
    endtask

    // Present one instruction at a negedge while idle; returns at the negedge of cycle T+1
    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        instr = ins; rs1_data = a; rs2_data = b; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, r1, r2;
        logic [2:0]  lf [4];
        logic [2:0]  f3;
        rd = 5'($urandom_range(0, 7));
        r1 = 5'($urandom);
        r2 = 5'($urandom);
        f3 = 3'($urandom);
        lf = '{3'b000, 3'b111, 3'b110, 3'b010};
        case ($urandom_range(0, 9))
            0, 1:    return r_ins(($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r2, r1, 3'b000, rd);
            2, 3:    return r_ins(7'h00, r2, r1, lf[$urandom_range(1, 3)], rd);
            4, 5:    return i_ins(12'($urandom), r1, lf[$urandom_range(0, 3)], rd);
            6:       return r_ins(7'($urandom), r2, r1, f3, rd);
            7:       return i_ins(12'($urandom), r1, f3, rd);
            8:       return $urandom;
            default: return r_ins(7'h20, r2, r1, f3, rd);
        endcase
    endfunction

    function automatic logic [31:0] rand_op();
        if ($urandom_range(0, 1) == 1) return $urandom;
        return 32'(int'($urandom_range(0, 20)) - 10);
    endfunction

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_srca", src_a, 32'd0);
        chk("rst_srcb", src_b, 32'd0);
        chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_wbrd", 32'(wb_rd), 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // R add x3 = x1 + x2
        wait_idle();
        wb_ready = 1'b1;
        send(r_ins(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7);
        chk("add_ctrl", 32'(alu_ctrl), 32'd0);
        chk("add_srca", src_a, 32'd5);
        chk("add_srcb", src_b, 32'd7);
        chk("add_ready_busy", 32'(instr_ready), 32'd0);
        @(negedge clk);
        chk("add_wbv_early", 32'(wb_valid), 32'd0);
        @(negedge clk);
        chk("add_wbv", 32'(wb_valid), 32'd1);
        chk("add_wbrd", 32'(wb_rd), 32'd3);
        chk("add_wbdata", wb_data, 32'd12);
        @(negedge clk);
        chk("add_ready_after", 32'(instr_ready), 32'd1);

        // R sub, then I andi with imm 0xFFF
        wait_idle();
        send(r_ins(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 32'd10, 32'd3);
        chk("sub_ctrl", 32'(alu_ctrl), 32'd1);
        repeat (2) @(negedge clk);
        chk("sub_wbv", 32'(wb_valid), 32'd1);
        chk("sub_wbdata", wb_data, 32'd7);
        wait_idle();
        send(i_ins(12'hFFF, 5'd1, 3'b111, 5'd5), 32'h1234, 32'h0);
        chk("andi_srcb", src_b, 32'hFFFFFFFF);
        chk("andi_ctrl", 32'(alu_ctrl), 32'd2);
        repeat (2) @(negedge clk);
        chk("andi_wbdata", wb_data, 32'h1234);

        // Writeback back-pressure with a new instruction already waiting
        wait_idle();
        wb_ready = 1'b0;
        send(r_ins(7'h00, 5'd2, 5'd1, 3'b110, 5'd6), 32'hF0, 32'h0F);
        instr = r_ins(7'h00, 5'd2, 5'd1, 3'b000, 5'd7);
        rs1_data = 32'd100; rs2_data = 32'd23; instr_valid = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_wbv", 32'(wb_valid), 32'd1);
            chk("hold_wbrd", 32'(wb_rd), 32'd6);
            chk("hold_wbdata", wb_data, 32'hFF);
            chk("hold_ready", 32'(instr_ready), 32'd0);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("rel_wbv", 32'(wb_valid), 32'd0);
        chk("rel_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("next_accept_ready", 32'(instr_ready), 32'd0);
        chk("next_accept_srca", src_a, 32'd100);

        // Unsupported load opcode
        wait_idle();
        send({12'h0, 5'd0, 3'b010, 5'd8, 7'b0000011}, 32'd1, 32'd2);
        chk("ld_illegal", 32'(illegal), 32'd1);
        chk("ld_wbv", 32'(wb_valid), 32'd0);
        chk("ld_ctrl", 32'(alu_ctrl), 32'd0);
        @(negedge clk);
        chk("ld_illegal_off", 32'(illegal), 32'd0);
        chk("ld_ready", 32'(instr_ready), 32'd1);

        // Reset in the middle of WAIT
        wait_idle();
        send(r_ins(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ready", 32'(instr_ready), 32'd1);
        chk("mrst_srca", src_a, 32'd0);
        chk("mrst_srcb", src_b, 32'd0);
        chk("mrst_ctrl", 32'(alu_ctrl), 32'd0);
        chk("mrst_wbv", 32'(wb_valid), 32'd0);
        chk("mrst_wbrd", 32'(wb_rd), 32'd0);
        chk("mrst_wbdata", wb_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mrst_no_late_wb", 32'(wb_valid), 32'd0);
        end
        send(r_ins(7'h00, 5'd2, 5'd1, 3'b000, 5'd9), 32'd1, 32'd2);
        repeat (2) @(negedge clk);
        chk("mrst_next_wbv", 32'(wb_valid), 32'd1);
        chk("mrst_next_wbrd", 32'(wb_rd), 32'd9);
        chk("mrst_next_wbdata", wb_data, 32'd3);

        // ALU_LAT=3 build: addi to x0, then addi to x2
        ins3 = i_ins(12'd5, 5'd1, 3'b000, 5'd0); a3 = 32'd100; iv3 = 1'b1;
        @(negedge clk);
        iv3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("l3_srca", src_a3, 32'd100);
            chk("l3_srcb", src_b3, 32'd5);
            chk("l3_ctrl", 32'(ctrl3), 32'd0);
            chk("l3_ready", 32'(ready3), 32'd0);
            chk("l3_wbv", 32'(wbv3), 32'd0);
            @(negedge clk);
        end
        chk("l3_ready_back", 32'(ready3), 32'd1);
        chk("l3_wbv_none", 32'(wbv3), 32'd0);
        ins3 = i_ins(12'hFFE, 5'd1, 3'b000, 5'd2); iv3 = 1'b1;
        @(negedge clk);
        iv3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("l3_wbv_early", 32'(wbv3), 32'd0);
        @(negedge clk);
        chk("l3_wbv", 32'(wbv3), 32'd1);
        chk("l3_wbrd", 32'(rd3), 32'd2);
        chk("l3_wbdata", wb_data3, 32'd98);

        // Randomized traffic with occasional asynchronous resets
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            instr_valid = ($urandom_range(0, 3) != 0);
            instr       = rand_instr();
            rs1_data    = rand_op();
            rs2_data    = rand_op();
            wb_ready    = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        instr_valid = 1'b0;
        wb_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
